// File: rtl/benes_loop_colorer.sv
// Looping-algorithm colourer for the outer stages of an 8-port Benes network.
// Each input/output is assigned to the upper (0) or lower (1) subnetwork, walking one constraint step per clock.
module benes_loop_colorer (
  input  logic       clk,
  input  logic       areset,
  input  logic       start,
  input  logic [2:0] mp0,
  input  logic [2:0] mp1,
  input  logic [2:0] mp2,
  input  logic [2:0] mp3,
  input  logic [2:0] mp4,
  input  logic [2:0] mp5,
  input  logic [2:0] mp6,
  input  logic [2:0] mp7,
  output logic [7:0] ci,
  output logic [7:0] co,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SEED, WALK, DONE} state_t;

  state_t     state_reg;
  logic [2:0] mpl_reg [8];
  logic [3:0] visited_reg;
  logic [2:0] cur_reg;
  logic [7:0] ci_reg;
  logic [7:0] co_reg;
  logic       done_reg;

  logic [2:0] mp_in [8];
  logic [2:0] mn [8];
  logic [2:0] nb [8];

  assign mp_in[0] = mp0;
  assign mp_in[1] = mp1;
  assign mp_in[2] = mp2;
  assign mp_in[3] = mp3;
  assign mp_in[4] = mp4;
  assign mp_in[5] = mp5;
  assign mp_in[6] = mp6;
  assign mp_in[7] = mp7;

  // Inverse permutation; unreached entries default to 0 for a non-permutation.
  always_comb begin
    for (int v = 0; v < 8; v++) mn[v] = 3'd0;
    for (int i = 0; i < 8; i++) mn[mpl_reg[i]] = 3'(i);
  end

  // nb[i] shares an output switch with input i, so it must take the other colour.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nb
      assign nb[gi] = mn[mpl_reg[gi] ^ 3'd1];
    end
  endgenerate

  logic       seed_found;
  logic [1:0] seed_k;

  always_comb begin
    seed_found = 1'b0;
    seed_k     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!visited_reg[k]) begin
        seed_found = 1'b1;
        seed_k     = 2'(k);
      end
    end
  end

  logic [2:0] walk_j;
  logic [2:0] walk_jp;
  logic       walk_c;
  logic       walk_closed;
  logic [2:0] seed_lo;
  logic [2:0] seed_hi;

  assign walk_j      = nb[cur_reg];
  assign walk_jp     = walk_j ^ 3'd1;
  assign walk_c      = ci_reg[cur_reg];
  assign walk_closed = visited_reg[walk_j[2:1]];
  assign seed_lo     = {seed_k, 1'b0};
  assign seed_hi     = {seed_k, 1'b1};

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_reg   <= IDLE;
      visited_reg <= 4'd0;
      cur_reg     <= 3'd0;
      ci_reg      <= 8'd0;
      co_reg      <= 8'd0;
      done_reg    <= 1'b0;
      for (int i = 0; i < 8; i++) mpl_reg[i] <= 3'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) mpl_reg[i] <= mp_in[i];
            visited_reg <= 4'd0;
            ci_reg      <= 8'd0;
            co_reg      <= 8'd0;
            done_reg    <= 1'b0;
            state_reg   <= SEED;
          end
        end
        SEED: begin
          if (!seed_found) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            ci_reg[seed_lo]          <= 1'b0;
            ci_reg[seed_hi]          <= 1'b1;
            co_reg[mpl_reg[seed_lo]] <= 1'b0;
            co_reg[mpl_reg[seed_hi]] <= 1'b1;
            visited_reg[seed_k]      <= 1'b1;
            cur_reg                  <= seed_lo;
            state_reg                <= WALK;
          end
        end
        WALK: begin
          if (walk_closed) begin
            state_reg <= SEED;
          end else begin
            ci_reg[walk_j]               <= ~walk_c;
            ci_reg[walk_jp]              <= walk_c;
            co_reg[mpl_reg[walk_j]]      <= ~walk_c;
            co_reg[mpl_reg[walk_jp]]     <= walk_c;
            visited_reg[walk_j[2:1]]     <= 1'b1;
            cur_reg                      <= walk_jp;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ci   = ci_reg;
  assign co   = co_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_benes_loop_colorer.sv
// Scoreboard bench for benes_loop_colorer: stimulus queues expectations, a monitor checks each completed result.
module tb_benes_loop_colorer;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mp [8];
  logic [7:0] ci;
  logic [7:0] co;
  logic       done;

  always #5 clk = ~clk;

  benes_loop_colorer dut (
    .clk(clk), .areset(areset), .start(start),
    .mp0(mp[0]), .mp1(mp[1]), .mp2(mp[2]), .mp3(mp[3]),
    .mp4(mp[4]), .mp5(mp[5]), .mp6(mp[6]), .mp7(mp[7]),
    .ci(ci), .co(co), .done(done)
  );

  typedef struct packed {
    bit          exact;
    logic [7:0]  eci;
    logic [7:0]  eco;
    int          lat;
    int          t0;
    logic [23:0] mv;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every rising done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    int   l;
    bit   ok;
    logic [2:0] idx;
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        l = cyc - e.t0 - 1;
        txn++;
        if (e.exact) begin
          check("ci", int'(ci), int'(e.eci));
          check("co", int'(co), int'(e.eco));
          check("latency", l, e.lat);
        end else begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (ci[2*k] == ci[2*k+1]) ok = 1'b0;
            if (co[2*k] == co[2*k+1]) ok = 1'b0;
          end
          for (int i = 0; i < 8; i++) begin
            idx = e.mv[3*i +: 3];
            if (co[idx] != ci[i]) ok = 1'b0;
          end
          check("invariants", int'(ok), 1);
          check("latency_bound", int'(l <= 13), 1);
        end
        $display("txn %0d mp=%h ci=%h co=%h latency=%0d", txn, e.mv, ci, co, l);
      end
    end
    done_q = done;
  end

  task automatic launch(input logic [23:0] mv, input bit exact, input logic [7:0] eci,
                        input logic [7:0] eco, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 8; i++) mp[i] = mv[3*i +: 3];
    start = 1'b1;
    e.exact = exact; e.eci = eci; e.eco = eco; e.lat = lat; e.t0 = cyc; e.mv = mv;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  localparam logic [23:0] MV_EX   = {3'd3, 3'd1, 3'd7, 3'd0, 3'd4, 3'd5, 3'd2, 3'd6};
  localparam logic [23:0] MV_ID   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] MV_SWAP = {3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t0;
    int   p [8];
    int   j;
    int   tmp;
    logic [23:0] mv;

    for (int i = 0; i < 8; i++) mp[i] = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_ci", int'(ci), 0);
    check("reset_co", int'(co), 0);
    check("reset_done", int'(done), 0);

    // Reset has priority over start: no run may be launched.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    areset = 1'b1;
    repeat (15) @(negedge clk);
    check("reset_beats_start", int'(done), 0);

    launch(MV_EX, 1'b1, 8'h6A, 8'h96, 7, 1'b1);
    drain();
    launch(MV_ID, 1'b1, 8'hAA, 8'hAA, 9, 1'b1);
    drain();
    launch(MV_SWAP, 1'b1, 8'hAA, 8'h55, 9, 1'b1);
    drain();

    // Start held high: ignored while busy, relaunches from DONE.
    @(negedge clk);
    for (int i = 0; i < 8; i++) mp[i] = MV_EX[3*i +: 3];
    start = 1'b1;
    t0 = cyc;
    e.exact = 1'b1; e.eci = 8'h6A; e.eco = 8'h96; e.lat = 7; e.mv = MV_EX;
    e.t0 = t0;
    sb.push_back(e);
    e.t0 = t0 + 8;
    sb.push_back(e);
    repeat (9) @(negedge clk);
    check("held_start_done_drop", int'(done), 0);
    repeat (7) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a walk aborts the run.
    launch(MV_EX, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check("midrun_reset_ci", int'(ci), 0);
    check("midrun_reset_co", int'(co), 0);
    check("midrun_reset_done", int'(done), 0);
    areset = 1'b1;
    launch(MV_EX, 1'b1, 8'h6A, 8'h96, 7, 1'b1);
    drain();

    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < 8; i++) p[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      for (int i = 0; i < 8; i++) mv[3*i +: 3] = 3'(p[i]);
      launch(mv, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/benes_loop_colorer.md
Name: benes_loop_colorer

Overview:
- Computes the switch-colouring for the first and last stage of an 8-port Benes network using the looping algorithm. It takes a destination permutation and assigns each input and each output to the upper (0) or lower (1) subnetwork.
- Self-contained: internally derives the inverse permutation (mn) and the partner-constraint table (nb), then walks the constraint loops one step per clock.
- Sits between the permutation source and the Benes switch-setting logic.

Parameters:
- None. N=8 ports and 3-bit port indices are fixed.

Ports:
- clk  input  1  rising-edge clock
- areset  input  1  synchronous, active-low reset
- start  input  1  level-sampled request; begins a colouring run
- mp0..mp7  input  3 each  mpX = output port that input X is routed to; must be a permutation of 0..7
- ci  output  8  ci[i] = subnetwork of input i (0 upper, 1 lower)
- co  output  8  co[j] = subnetwork of output j
- done  output  1  high when ci/co hold a completed result

Behaviour:
- Reset (areset=0 at a rising edge): state=IDLE; ci, co, done, visited and cur all 0. Reset mid-run aborts immediately. Reset wins over start.
- Combinational tables, computed from the latched permutation mpl:
  - mn[mpl[i]] = i
  - nb[i] = mn[mpl[i]^1], the input that must take the opposite colour to input i.
- Colouring rules:
  - Pairs (2k, 2k+1) always get opposite colours.
  - When ci[x] is written, co[mpl[x]] is written with the same value.
- FSM states: IDLE, SEED, WALK, DONE.
- IDLE or DONE, start=1:
  - latch mp0..7 into mpl; clear visited[3:0], ci, co, done; go to SEED.
  - start is ignored in SEED and WALK.
- SEED: find the lowest unvisited pair k.
  - None left: go to DONE, done<=1.
  - Otherwise: ci[2k]<=0, ci[2k+1]<=1 (co updated accordingly); visited[k]<=1; cur<=2k; go to WALK.
- WALK, with j = nb[cur] and c = ci[cur]:
  - visited[j>>1]=1 (loop closed): go to SEED.
  - Otherwise: ci[j]<=~c, ci[j^1]<=c (co updated accordingly); visited[j>>1]<=1; cur<=j^1; stay in WALK.
- Timing and outputs:
  - Run length is ≤ 4 SEED + 8 WALK + 1 final SEED cycles, so done rises within 13 edges after the start-sampling edge.
  - ci/co/done hold until the next accepted start or reset.
- Non-permutation mp: the run still terminates within the same bound. ci/co contents are unspecified.
- Result invariants for a valid permutation:
  - ci[2k] != ci[2k+1]
  - co[2k] != co[2k+1]
  - co[mp[i]] = ci[i]

Test Plan:
- Reset, then mp=6,2,5,4,0,7,1,3, start for one cycle:
  - internal mn=4,6,1,7,3,2,0,5; nb=5,7,3,2,6,0,4,1
  - done rises exactly 7 edges after the start-sampling edge
  - ci=8'h6A, co=8'h96
- Identity mp=0..7 -> ci=8'hAA, co=8'hAA; done after 9 edges (4 seeds, each closing immediately, plus the final SEED).
- mp=1,0,3,2,5,4,7,6 (pair swap) -> ci=8'hAA, co=8'h55.
- Hold start high continuously:
  - start is ignored while busy.
  - In DONE, start re-launches the run: done drops for one cycle, then the same result reappears.
- Assert areset=0 mid-WALK -> next edge: ci=co=0, done=0, state IDLE. A later start produces a correct full result.
- Random permutations (≥1000): check every result invariant and the 13-cycle latency bound.
